// File: rtl/rtr_flit_buffer_pkg.sv
// Shared constants and helpers for the VC flit buffer.
// Default geometry and error-bit layout of errors_ivc.
package rtr_flit_buffer_pkg;

    // Ceiling log2, never less than 1 so a pointer is always at least 1 bit.
    function automatic int clogb(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_NUM_VCS     = 8;
    localparam int DEF_BUFFER_SIZE = 64;
    localparam int DEF_VC_DEPTH    = DEF_BUFFER_SIZE / DEF_NUM_VCS;
    localparam int DEF_PTR_W       = clogb(DEF_VC_DEPTH);

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;

endpackage

// File: rtl/rtr_fb_vc_fifo.sv
// Single-VC circular FIFO with count, head/next read ports,
// same-cycle bypass detection and registered error flags.
module rtr_fb_vc_fifo
    import rtr_flit_buffer_pkg::*;
#(
    parameter int depth     = 8,
    parameter int width     = 65,
    parameter bit bypass_en = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] head,
    output logic [width-1:0] next,
    output logic             empty,
    output logic             almost_empty,
    output logic             full,
    output logic             many,
    output logic             bypass,
    output logic [1:0]       errors
);

    localparam int ptr_w = clogb(depth);
    localparam int cnt_w = clogb(depth + 1);
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(depth);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(depth - 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w-1:0] rd_nxt;
    logic [cnt_w-1:0] count;
    logic             do_write;
    logic             do_read;
    logic             underflow;
    logic             overflow;

    function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
        return (p == ptr_last) ? '0 : p + ptr_w'(1);
    endfunction

    assign empty        = (count == '0);
    assign almost_empty = (count == cnt_w'(1));
    assign full         = (count == cnt_max);
    assign many         = (count >= cnt_w'(2));

    // Bypass forwards the incoming flit straight out and leaves the VC empty.
    assign bypass    = bypass_en & push & pop & empty;
    // At full a simultaneous pop frees the slot being written.
    assign do_write  = push & ~bypass & (~full | pop);
    assign do_read   = pop & ~empty;
    assign underflow = pop & empty & ~bypass;
    assign overflow  = push & full & ~pop;

    assign rd_nxt = inc(rd_ptr);
    assign head   = mem[rd_ptr];
    assign next   = mem[rd_nxt];

    // Storage write; contents are deliberately left uncleared on reset.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            errors <= '0;
        end else begin
            errors[ERR_UNDERFLOW] <= underflow;
            errors[ERR_OVERFLOW]  <= overflow;
            if (do_write) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= rd_nxt;
            end
            if (do_write && !do_read) begin
                count <= count + cnt_w'(1);
            end else if (!do_write && do_read) begin
                count <= count - cnt_w'(1);
            end
        end
    end

endmodule

// File: rtl/rtr_flit_buffer.sv
// Input flit buffer: one static circular FIFO per VC, one push and
// one pop per cycle, bypass, occupancy status and error flags.
module rtr_flit_buffer
    import rtr_flit_buffer_pkg::*;
#(
    parameter int num_vcs           = DEF_NUM_VCS,
    parameter int buffer_size       = DEF_BUFFER_SIZE,
    parameter int flit_data_width   = 64,
    parameter int header_info_width = 64,
    parameter bit enable_bypass     = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_active,
    input  logic                         push_valid,
    input  logic [num_vcs-1:0]           push_sel_ivc,
    input  logic                         push_head,
    input  logic                         push_tail,
    input  logic [flit_data_width-1:0]   push_data,
    input  logic                         pop_active,
    input  logic                         pop_valid,
    input  logic [num_vcs-1:0]           pop_sel_ivc,
    output logic [flit_data_width-1:0]   pop_data,
    output logic [num_vcs-1:0]           pop_tail_ivc,
    output logic [header_info_width-1:0] pop_next_header_info,
    output logic [num_vcs-1:0]           almost_empty_ivc,
    output logic [num_vcs-1:0]           empty_ivc,
    output logic                         full,
    output logic [2*num_vcs-1:0]         errors_ivc
);

    localparam int depth   = buffer_size / num_vcs;
    localparam int entry_w = flit_data_width + 1;

    logic [entry_w-1:0] head [num_vcs];
    logic [entry_w-1:0] next [num_vcs];
    logic [num_vcs-1:0] full_ivc;
    logic [num_vcs-1:0] many_ivc;
    logic [num_vcs-1:0] bypass_ivc;
    logic [num_vcs-1:0] push_ivc;
    logic [num_vcs-1:0] pop_ivc;
    logic [num_vcs-1:0] unused_next;
    logic               unused_head;

    assign push_ivc = {num_vcs{push_active & push_valid}} & push_sel_ivc;
    assign pop_ivc  = {num_vcs{pop_active & pop_valid}} & pop_sel_ivc;

    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
        rtr_fb_vc_fifo #(
            .depth    (depth),
            .width    (entry_w),
            .bypass_en(enable_bypass)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push_ivc[v]),
            .pop         (pop_ivc[v]),
            .wr_data     ({push_tail, push_data}),
            .head        (head[v]),
            .next        (next[v]),
            .empty       (empty_ivc[v]),
            .almost_empty(almost_empty_ivc[v]),
            .full        (full_ivc[v]),
            .many        (many_ivc[v]),
            .bypass      (bypass_ivc[v]),
            .errors      (errors_ivc[2*v +: 2])
        );

        assign pop_tail_ivc[v] = empty_ivc[v] ? (bypass_ivc[v] & push_tail)
                                              : head[v][entry_w-1];
        assign unused_next[v]  = ^next[v];
    end

    // Partitions are equal, so the port is full exactly when every VC is.
    assign full        = &full_ivc;
    assign unused_head = push_head;

    // One-hot pop select mux with bypass override for an empty VC.
    always_comb begin
        pop_data             = '0;
        pop_next_header_info = '0;
        for (int v = 0; v < num_vcs; v++) begin
            if (pop_sel_ivc[v]) begin
                pop_data = bypass_ivc[v] ? push_data
                                         : head[v][flit_data_width-1:0];
                if (many_ivc[v]) begin
                    pop_next_header_info = next[v][header_info_width-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rtr_flit_buffer.sv
// Self-checking bench for rtr_flit_buffer: per-VC scoreboard queues
// are filled on push and drained/compared on pop.
module tb_rtr_flit_buffer;

    localparam int NV = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_active, push_valid, push_head, push_tail;
    logic [NV-1:0] push_sel_ivc;
    logic [63:0]   push_data;
    logic          pop_active, pop_valid;
    logic [NV-1:0] pop_sel_ivc;
    logic [63:0]   pop_data;
    logic [NV-1:0] pop_tail_ivc;
    logic [63:0]   pop_next_header_info;
    logic [NV-1:0] almost_empty_ivc, empty_ivc;
    logic          full;
    logic [2*NV-1:0] errors_ivc;

    int vectors = 0;
    int miscompares = 0;

    logic [64:0]     sbq [NV][$];
    logic [2*NV-1:0] exp_err;

    always #5 clk = ~clk;

    rtr_flit_buffer dut (
        .clk                 (clk),
        .reset               (reset),
        .push_active         (push_active),
        .push_valid          (push_valid),
        .push_sel_ivc        (push_sel_ivc),
        .push_head           (push_head),
        .push_tail           (push_tail),
        .push_data           (push_data),
        .pop_active          (pop_active),
        .pop_valid           (pop_valid),
        .pop_sel_ivc         (pop_sel_ivc),
        .pop_data            (pop_data),
        .pop_tail_ivc        (pop_tail_ivc),
        .pop_next_header_info(pop_next_header_info),
        .almost_empty_ivc    (almost_empty_ivc),
        .empty_ivc           (empty_ivc),
        .full                (full),
        .errors_ivc          (errors_ivc)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        push_active  = 1'b0;
        push_valid   = 1'b0;
        push_sel_ivc = '0;
        push_head    = 1'b0;
        push_tail    = 1'b0;
        push_data    = '0;
        pop_active   = 1'b0;
        pop_valid    = 1'b0;
        pop_sel_ivc  = '0;
    endtask

    task automatic check_status();
        logic [NV-1:0] e, a;
        logic f;
        f = 1'b1;
        for (int v = 0; v < NV; v++) begin
            e[v] = (sbq[v].size() == 0);
            a[v] = (sbq[v].size() == 1);
            if (sbq[v].size() != DP) f = 1'b0;
        end
        chk("empty_ivc", 64'(empty_ivc), 64'(e));
        chk("almost_empty_ivc", 64'(almost_empty_ivc), 64'(a));
        chk("full", 64'(full), 64'(f));
        chk("errors_ivc", 64'(errors_ivc), 64'(exp_err));
    endtask

    // One cycle: optional push (pvc>=0) and optional pop (qvc>=0).
    task automatic op(input int pvc, input logic [63:0] d,
                      input logic t, input int qvc);
        logic [64:0] ent;
        logic        byp;
        logic        qne;
        exp_err = '0;
        idle();
        if (pvc >= 0) begin
            push_active = 1'b1;
            push_valid  = 1'b1;
            push_sel_ivc[pvc] = 1'b1;
            push_data   = d;
            push_tail   = t;
        end
        if (qvc >= 0) begin
            pop_active = 1'b1;
            pop_valid  = 1'b1;
            pop_sel_ivc[qvc] = 1'b1;
        end
        #1;
        byp = (qvc >= 0) && (pvc == qvc) && (sbq[qvc].size() == 0);
        qne = (qvc >= 0) && (sbq[qvc].size() != 0);
        if (qvc >= 0) begin
            if (qne) begin
                ent = sbq[qvc][0];
                chk("pop_data", pop_data, ent[63:0]);
                chk("pop_tail", 64'(pop_tail_ivc[qvc]), 64'(ent[64]));
                if (sbq[qvc].size() >= 2) begin
                    ent = sbq[qvc][1];
                    chk("next_hdr", pop_next_header_info, ent[63:0]);
                end else begin
                    chk("next_hdr", pop_next_header_info, 64'h0);
                end
            end else if (byp) begin
                chk("byp_data", pop_data, d);
                chk("byp_tail", 64'(pop_tail_ivc[qvc]), 64'(t));
            end else begin
                exp_err[2*qvc] = 1'b1;
            end
        end
        if (pvc >= 0 && !byp) begin
            if (sbq[pvc].size() < DP || (qvc == pvc)) begin
                sbq[pvc].push_back({t, d});
            end else begin
                exp_err[2*pvc+1] = 1'b1;
            end
        end
        if (qne) void'(sbq[qvc].pop_front());
        @(posedge clk);
        #1;
        idle();
        check_status();
    endtask

    initial begin
        idle();
        exp_err = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        reset = 1'b1;

        op(2, 64'hA1, 1'b0, -1);
        chk("vc2_head", pop_data, 64'h0);
        op(-1, 0, 1'b0, 2);

        op(5, 64'h55, 1'b1, 5);

        for (int i = 0; i < DP; i++) op(0, 64'(i), 1'b0, -1);
        op(0, 64'h99, 1'b0, -1);
        op(0, 64'h77, 1'b1, 0);
        for (int i = 0; i < DP; i++) op(-1, 0, 1'b0, 0);

        op(-1, 0, 1'b0, 3);
        op(3, 64'h33, 1'b0, -1);
        op(-1, 0, 1'b0, 3);

        for (int v = 0; v < NV; v++)
            for (int i = 0; i < DP; i++)
                op(v, 64'((v << 8) | i), i[0], -1);
        op(-1, 0, 1'b0, 4);
        for (int v = 0; v < NV; v++)
            while (sbq[v].size() != 0) op(-1, 0, 1'b0, v);

        op(7, 64'h700, 1'b0, -1);
        op(7, 64'h701, 1'b1, -1);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) op(7, 64'h800 + 64'(i), i[0], 7);
            else if (i % 3 == 1) op(7, 64'h900 + 64'(i), 1'b0, -1);
            else op(-1, 0, 1'b0, 7);
        end
        while (sbq[7].size() != 0) op(-1, 0, 1'b0, 7);

        op(1, 64'h11, 1'b0, -1);
        op(6, 64'h66, 1'b0, -1);
        push_active = 1'b1;
        push_valid  = 1'b1;
        push_sel_ivc = 8'h02;
        push_data   = 64'hDEAD;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        for (int v = 0; v < NV; v++) sbq[v].delete();
        exp_err = '0;
        check_status();
        op(-1, 0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtr_flit_buffer.md
Name: rtr_flit_buffer

Overview:
- Input-side flit buffer for a virtual-channel router port or network sink.
- Buffer storage is statically partitioned into one circular FIFO per VC.
- Each cycle it accepts at most one flit push and performs at most one flit pop, each steered by a one-hot VC select.
- Provides same-cycle bypass, per-VC occupancy status and per-VC error flags.

Parameters:
- num_vcs, 8, number of virtual channels.
- buffer_size, 64, total flit entries per port. Depth per VC is buffer_size/num_vcs and must be at least 2.
- flit_data_width, 64, payload bits per flit.
- header_info_width, 64, width of pop_next_header_info. Must be <= flit_data_width.
- enable_bypass, 1, allows an empty VC to forward the flit being pushed in the same cycle.

Ports:
- clk  in  1  rising-edge clock. This is the only clock.
- reset  in  1  synchronous, active-low reset.
- push_active  in  1  push-side enable. When low, no push occurs.
- push_valid  in  1  a flit is presented for writing.
- push_sel_ivc  in  num_vcs  one-hot target VC for the push.
- push_head  in  1  head flag (informational, not stored).
- push_tail  in  1  tail flag, stored with the flit.
- push_data  in  flit_data_width  flit payload.
- pop_active  in  1  pop-side enable.
- pop_valid  in  1  pop request.
- pop_sel_ivc  in  num_vcs  one-hot VC to pop from.
- pop_data  out  flit_data_width  data of the flit popped from the selected VC.
- pop_tail_ivc  out  num_vcs  per VC, tail flag of that VC's next-to-pop flit.
- pop_next_header_info  out  header_info_width  leading bits of the entry behind the head of the selected VC.
- almost_empty_ivc  out  num_vcs  per VC, occupancy == 1.
- empty_ivc  out  num_vcs  per VC, occupancy == 0.
- full  out  1  total occupancy == buffer_size.
- errors_ivc  out  2*num_vcs  per VC v: bit 2v = underflow, bit 2v+1 = overflow.

Behaviour:
- Push condition: push_active & push_valid. Pop condition: pop_active & pop_valid. Select vectors must be one-hot when the corresponding condition is true; otherwise behaviour is undefined.
- Each VC holds a write pointer, a read pointer (both wrapping modulo the per-VC depth) and a count (0..depth). Storage holds {tail, data} per entry.
- pop_data is combinational and equals the head entry of the VC selected by pop_sel_ivc.
- Bypass applies when enable_bypass=1, the selected VC is empty, and a push targets the same VC in the same cycle.
  - pop_data = push_data.
  - Nothing is stored and the count stays at 0.
- Push and pop on the same non-empty VC in one cycle: the count is unchanged, and both pointers advance.
  - This is legal at full, which gives full throughput.
- Push and pop on different VCs are independent.
- pop_tail_ivc[v]:
  - stored tail flag of v's head entry when v is non-empty;
  - else push_tail if v is the bypass target;
  - else 0.
- pop_next_header_info: the first header_info_width bits of the entry at read pointer+1 of the selected VC when its count >= 2, else zero.
- empty_ivc, almost_empty_ivc and full are decoded from the registered counts only, with no combinational input dependence.
- Error flags are registered and updated every cycle; each is high for exactly the cycle after the offending event.
  - Underflow: a pop to an empty VC with no bypass. Count and pointers are unchanged.
  - Overflow: a push to a full VC with no simultaneous pop to it. The flit is dropped and state is unchanged.
- Reset (reset low at a clock edge), even mid-operation:
  - all counts and pointers become 0;
  - errors_ivc becomes 0;
  - empty_ivc becomes all ones, almost_empty_ivc 0, full 0;
  - storage contents need not be cleared;
  - push and pop are ignored during that cycle.
- Latency: a pushed flit is visible as the VC head (pop_data, and empty_ivc deasserted) in the cycle after the push. Through bypass it is visible in the same cycle.

Decomposition:
- Shared package/include:
  - clogb function;
  - per-VC depth and pointer-width localparams;
  - error bit index constants (underflow offset 0, overflow offset 1).
- One sub-module, rtr_fb_vc_fifo: single-VC circular FIFO with count, head/next-entry read ports and error detection.
- The top instantiates num_vcs copies.
- The top also contains the output mux (pop_data, pop_next_header_info), the bypass path and the full reduction.

Test Plan (num_vcs=8, buffer_size=64, depth 8):
- Reset low 2 cycles -> empty_ivc=8'hFF, almost_empty_ivc=0, full=0, errors_ivc=0.
- Push 0xA1 to VC2 with no pop -> next cycle: empty_ivc[2]=0, almost_empty_ivc[2]=1, pop_data with pop_sel=VC2 = 0xA1. Then pop -> VC2 empty, no error.
- VC5 empty; push 0x55 (tail=1) and pop VC5 in the same cycle -> same-cycle pop_data=0x55, pop_tail_ivc[5]=1; next cycle empty_ivc[5]=1, errors_ivc=0.
- Push 8 flits 0..7 to VC0; push a 9th with no pop -> next cycle errors_ivc[1]=1, contents still 0..7 in order. Push and pop together at full -> no error, count stays 8.
- Pop VC3 while empty with no push -> next cycle errors_ivc[6]=1, pointers unchanged.
- Fill all VCs (64 pushes) -> full=1; then one pop -> full=0. Pointer wrap check: 20 interleaved push/pop on VC7 preserve FIFO order.
